xn_seg7_scan: RTL and testbench

XN_SEG7_SCAN -- requirements
Module: xn_seg7_scan

---
 rtl/xn_seg7_scan.sv | 158 +++++++++++++++
 tb/tb_xn_seg7_scan.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xn_seg7_scan.sv
// Multiplexed hex 7-segment scanner with a frame-synchronous double-buffered display value.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module xn_seg7_scan #(
  parameter int DIGITS     = 4,
  parameter int DIV        = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     wr_dp,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            cat,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] POL_AN     = {DIGITS{ACTIVE_LOW}};
  localparam logic [7:0]        POL_CAT    = {8{ACTIVE_LOW}};

  logic [PW-1:0]       r_presc;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_pend_data;
  logic [DIGITS-1:0]   r_pend_dp;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_disp_data;
  logic [DIGITS-1:0]   r_disp_dp;
  logic                r_frame_tick;
  logic [DIGITS-1:0]   r_an;
  logic [7:0]          r_cat;

  logic                w_presc_wrap;
  logic                w_boundary;
  logic [3:0]          w_nib;
  logic                w_dp;
  logic                w_blank;
  logic [6:0]          w_seg;
  logic [DIGITS-1:0]   w_onehot;

  assign w_presc_wrap = (r_presc == PRESC_LAST);
  assign w_boundary   = w_presc_wrap && (r_idx == IDX_LAST);
  assign w_onehot     = DIGITS'(1) << r_idx;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
      if (w_presc_wrap)
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
  end

  // A write on the boundary itself goes straight to the display and never sets pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pending    <= 1'b0;
      r_disp_data  <= '0;
      r_disp_dp    <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      if (w_boundary) begin
        if (wr_en) begin
          r_disp_data <= wr_data;
          r_disp_dp   <= wr_dp;
        end else if (r_pending) begin
          r_disp_data <= r_pend_data;
          r_disp_dp   <= r_pend_dp;
        end
        r_pending <= 1'b0;
      end else if (wr_en) begin
        r_pend_data <= wr_data;
        r_pend_dp   <= wr_dp;
        r_pending   <= 1'b1;
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic [DIGITS-1:0] w_lz;

  always_comb begin : lzb_scan
    logic run;
    run  = 1'b1;
    w_lz = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run     = run && (r_disp_data[4*i +: 4] == 4'h0);
      w_lz[i] = run;
    end
  end
`endif

  // NOTE: every comb output gets a default before the loop/case so no latch can be inferred.
  always_comb begin
    w_nib   = 4'h0;
    w_dp    = 1'b0;
    w_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib = r_disp_data[4*i +: 4];
        w_dp  = r_disp_dp[i];
`ifdef SEG7_LZB_EN
        w_blank = w_lz[i] && (i != 0);
`endif
      end
    end
  end

  always_comb begin
    w_seg = 7'h00;
    case (w_nib)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      4'hF: w_seg = 7'h71;
      default: w_seg = 7'h00;
    endcase
  end

  // Anodes stay dark on the first cycle of each dwell to hide segment changeover.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= POL_AN;
      r_cat <= POL_CAT;
    end else begin
      r_an  <= (r_presc == '0) ? POL_AN : (w_onehot ^ POL_AN);
      r_cat <= {w_dp, (w_blank ? 7'h00 : w_seg)} ^ POL_CAT;
    end
  end

  assign an         = r_an;
  assign cat        = r_cat;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

endmodule

// File: tb/tb_xn_seg7_scan.sv
// Scoreboard bench for xn_seg7_scan (DIGITS=4, DIV=4): stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them. Honours SEG7_LZB_EN.
module tb_xn_seg7_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        wr_en   = 1'b0;
  logic [15:0] wr_data = '0;
  logic [3:0]  wr_dp   = '0;
  logic [3:0]  an;
  logic [7:0]  cat;
  logic        frame_tick;
  logic        pending;

  xn_seg7_scan #(.DIGITS(DIGITS), .DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_dp     (wr_dp),
    .an        (an),
    .cat       (cat),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef enum logic [1:0] {K_AN, K_CAT, K_TICK, K_PEND} kind_e;
  typedef struct {
    int          cyc;
    kind_e       kind;
    logic [7:0]  val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] mon_act;

  // Active-low hex glyphs, dp off.
  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
  endtask

  task automatic push(input int c, input kind_e k, input logic [7:0] v, input string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] exp_cat(input logic [15:0] v, input logic [3:0] dp, input int d);
    logic [7:0] c;
    c = glyph[v[4*d +: 4]];
`ifdef SEG7_LZB_EN
    if (d > 0 && (v >> (4*d)) == 16'h0) c = 8'hFF;
`endif
    if (dp[d]) c[7] = 1'b0;
    return c;
  endfunction

  // base = the gap cycle of digit 0 for a frame; each digit dwell is gap + 3 active cycles.
  task automatic exp_frame(input int base, input logic [15:0] v, input logic [3:0] dp, input string n);
    logic [3:0] a;
    for (int d = 0; d < DIGITS; d++) begin
      a = ~(4'b0001 << d);
      push(base + 4*d,     K_AN,  8'h0F,             $sformatf("%s_gap%0d", n, d));
      push(base + 4*d + 1, K_AN,  {4'h0, a},         $sformatf("%s_an%0d", n, d));
      push(base + 4*d + 1, K_CAT, exp_cat(v, dp, d), $sformatf("%s_cat%0d", n, d));
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a write so that edge e samples wr_en high.
  task automatic write(input int e, input logic [15:0] d, input logic [3:0] p);
    goto(e - 1);
    wr_en = 1'b1; wr_data = d; wr_dp = p;
    goto(e);
    wr_en = 1'b0;
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          K_AN:    mon_act = {4'h0, an};
          K_CAT:   mon_act = cat;
          K_TICK:  mon_act = {7'h0, frame_tick};
          default: mon_act = {7'h0, pending};
        endcase
        check(sb[i].name, mon_act, sb[i].val);
        sb.delete(i);
      end
    end
  end

  initial begin
    for (int c = 1; c <= 3; c++) begin
      push(c, K_AN,   8'h0F, "rst_an");
      push(c, K_CAT,  8'hFF, "rst_cat");
      push(c, K_PEND, 8'h00, "rst_pend");
      push(c, K_TICK, 8'h00, "rst_tick");
    end
    exp_frame(4, 16'h0000, 4'b0000, "first");
    push(18, K_TICK, 8'h00, "tick_pre");
    push(19, K_TICK, 8'h01, "tick_f0");
    push(20, K_TICK, 8'h00, "tick_post");
    push(34, K_TICK, 8'h00, "tick_mid");
    push(35, K_TICK, 8'h01, "tick_f1");
    push(9,  K_PEND, 8'h00, "pend_idle");
    push(10, K_PEND, 8'h01, "pend_set");
    push(18, K_PEND, 8'h01, "pend_hold");
    push(19, K_PEND, 8'h00, "pend_clr");
    exp_frame(20, 16'h12AF, 4'b0001, "f12af");
    goto(3);
    rst = 1'b0;
    write(10, 16'h12AF, 4'b0001);

    // Two writes in one frame: only the last reaches the display.
    exp_frame(36, 16'h12AF, 4'b0001, "hold");
    push(40, K_PEND, 8'h01, "lw_pend");
    push(51, K_PEND, 8'h00, "lw_clr");
    push(51, K_TICK, 8'h01, "tick_f2");
    exp_frame(52, 16'h2222, 4'b0000, "last_wins");
    write(40, 16'h1111, 4'b0000);
    write(44, 16'h2222, 4'b0000);

    // Write on the boundary edge itself.
    push(66, K_PEND, 8'h00, "byp_pend_a");
    push(67, K_PEND, 8'h00, "byp_pend_b");
    push(68, K_PEND, 8'h00, "byp_pend_c");
    push(67, K_TICK, 8'h01, "tick_f3");
    exp_frame(68, 16'h00A0, 4'b0000, "bypass");
    write(67, 16'h00A0, 4'b0000);

    // Reset mid-frame while a write is pending.
    push(90, K_PEND, 8'h01, "pend_mid");
    push(93, K_AN,   8'h0F, "rst2_an");
    push(93, K_CAT,  8'hFF, "rst2_cat");
    push(93, K_PEND, 8'h00, "rst2_pend");
    push(93, K_TICK, 8'h00, "rst2_tick");
    exp_frame(95, 16'h0000, 4'b0000, "rst2_f0");
    push(110, K_TICK, 8'h01, "rst2_tick_f0");
    push(111, K_PEND, 8'h00, "rst2_pend_f1");
    exp_frame(111, 16'h0000, 4'b0000, "rst2_f1");
    write(90, 16'h5555, 4'b1111);
    goto(92);
    rst = 1'b1;
    goto(94);
    rst = 1'b0;

    // Leading-zero value, then glyph sweeps covering the remaining nibbles.
    exp_frame(127, 16'h0070, 4'b0000, "lzb");
    write(115, 16'h0070, 4'b0000);
    exp_frame(143, 16'h3456, 4'b0000, "g3456");
    write(130, 16'h3456, 4'b0000);
    exp_frame(159, 16'h9BCD, 4'b1010, "g9bcd");
    write(146, 16'h9BCD, 4'b1010);
    exp_frame(175, 16'hE872, 4'b0000, "ge872");
    write(162, 16'hE872, 4'b0000);

    goto(192);
    @(negedge clk);
    #1;
    check("end_pend", {7'h0, pending}, 8'h00);
    check("end_tick", {7'h0, frame_tick}, 8'h00);
    check("end_an_onehot", {7'h0, ($countones(~an) <= 1)}, 8'h01);
    foreach (sb[i]) $display("FAIL %s never_checked got=none exp=%h", sb[i].name, sb[i].val);
    check("sb_empty", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
